uart_rx_frontend: RTL

UART receiver that deserializes the host serial line into bytes and presents them to the command FSM and the processor input path as `data` plus a level-held `rx_interrupt`. It sits directly upstream of the matrix/vector processing top: its `data` and `rx_interrupt` outputs feed that top's `data` and `rx_interrupt` inputs, and that top's `clear_interrupt` output returns here as the byte acknowledge. Framing is 8N1, with an optional parity bit. Framing and overrun errors are reported as sticky flags.

---
 rtl/uart_rx_frontend.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
// Oversampling UART receiver: 2-flop synchronizer, start-bit qualification at
// mid-bit, LSB-first deserialization, stop-bit check with break recovery.
// Delivers bytes as data + level-held rx_interrupt, acknowledged by a
// one-cycle clear_interrupt. Framing/overrun/parity errors are sticky flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> start + DATA_WIDTH + even parity + stop, parity_error live
//   undefined -> plain 8N1, PARITY state absent, parity_error tied to 0
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  clear_interrupt,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  rx_interrupt,
    output logic                  frame_error,
    output logic                  overrun,
    output logic                  parity_error
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    // Counter compare points: last cycle of half a bit and of a full bit
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        , ST_PARITY = 3'd5
`endif
    } state_t;

    // Even parity of a payload word: the parity bit that makes the total even
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] value);
        return ^value;
    endfunction

    logic [1:0]            rx_sync_r;
    logic                  rx_s;
    state_t                state_r;
    state_t                next_state_s;
    logic [CNT_W-1:0]      clk_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  rx_interrupt_r;
    logic                  frame_error_r;
    logic                  overrun_r;

    // Strobes decoded by the FSM for the datapath registers
    logic                  cnt_clr_s;
    logic                  bit_clr_s;
    logic                  sample_bit_s;
    logic                  stop_good_s;
    logic                  stop_bad_s;
`ifdef UART_RX_PARITY_EN
    logic                  par_sample_s;
    logic                  par_mismatch_s;
    logic                  par_bad_r;
    logic                  parity_error_r;
`endif

    // Two-flop synchronizer for the asynchronous serial line (idle high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_r <= 2'b11;
        end else begin
            rx_sync_r <= {rx_sync_r[0], rx};
        end
    end

    assign rx_s = rx_sync_r[1];

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and datapath strobes
    always_comb begin
        next_state_s = state_r;
        cnt_clr_s    = 1'b0;
        bit_clr_s    = 1'b0;
        sample_bit_s = 1'b0;
        stop_good_s  = 1'b0;
        stop_bad_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                cnt_clr_s = 1'b1;
                if (!rx_s) begin
                    bit_clr_s    = 1'b1;
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                // Re-check the line at mid start bit to reject glitches
                if (clk_cnt_r == HALF_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (rx_s) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (clk_cnt_r == FULL_LAST) begin
                    cnt_clr_s    = 1'b1;
                    sample_bit_s = 1'b1;
                    if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        next_state_s = ST_PARITY;
`else
                        next_state_s = ST_STOP;
`endif
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end else begin
                    next_state_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (clk_cnt_r == FULL_LAST) begin
                    cnt_clr_s    = 1'b1;
                    par_sample_s = 1'b1;
                    next_state_s = ST_STOP;
                end else begin
                    next_state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                // Sampling at mid stop bit leaves half a bit for the next start
                if (clk_cnt_r == FULL_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (rx_s) begin
                        stop_good_s  = 1'b1;
                        next_state_s = ST_IDLE;
                    end else begin
                        stop_bad_s   = 1'b1;
                        next_state_s = ST_BREAK;
                    end
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                // A line held low must return high before a new frame can start
                cnt_clr_s = 1'b1;
                if (rx_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_BREAK;
                end
            end
            default: begin
                cnt_clr_s    = 1'b1;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Bit-period cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_s) begin
            clk_cnt_r <= {CNT_W{1'b0}};
        end else begin
            clk_cnt_r <= clk_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Payload bit counter, cleared at every detected start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r <= {BIT_W{1'b0}};
        end else if (bit_clr_s) begin
            bit_cnt_r <= {BIT_W{1'b0}};
        end else if (sample_bit_s) begin
            bit_cnt_r <= bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
        end
    end

    // LSB-first shift register: new bits enter at the MSB and move down
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r <= {DATA_WIDTH{1'b0}};
        end else if (sample_bit_s) begin
            shift_r <= {rx_s, shift_r[DATA_WIDTH-1:1]};
        end
    end

    // Delivered byte and byte/error flags; a completing frame beats an acknowledge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r         <= {DATA_WIDTH{1'b0}};
            rx_interrupt_r <= 1'b0;
            frame_error_r  <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            if (stop_good_s) begin
                data_r <= shift_r;
            end

            if (stop_good_s) begin
                rx_interrupt_r <= 1'b1;
            end else if (clear_interrupt) begin
                rx_interrupt_r <= 1'b0;
            end

            // Overrun only when the previous byte was never acknowledged
            if (stop_good_s && rx_interrupt_r && !clear_interrupt) begin
                overrun_r <= 1'b1;
            end else if (clear_interrupt) begin
                overrun_r <= 1'b0;
            end

            if (stop_bad_s) begin
                frame_error_r <= 1'b1;
            end else if (clear_interrupt) begin
                frame_error_r <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_mismatch_s = (rx_s != even_parity(shift_r));

    // Remember this frame's parity result so it survives an acknowledge mid-frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad_r <= 1'b0;
        end else if (bit_clr_s) begin
            par_bad_r <= 1'b0;
        end else if (par_sample_s) begin
            par_bad_r <= par_mismatch_s;
        end
    end

    // Sticky parity flag: raised at the parity sample and reasserted on delivery
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_error_r <= 1'b0;
        end else if ((par_sample_s && par_mismatch_s) || (stop_good_s && par_bad_r)) begin
            parity_error_r <= 1'b1;
        end else if (clear_interrupt) begin
            parity_error_r <= 1'b0;
        end
    end

    assign parity_error = parity_error_r;
`else
    assign parity_error = 1'b0;
`endif

    assign data         = data_r;
    assign rx_interrupt = rx_interrupt_r;
    assign frame_error  = frame_error_r;
    assign overrun      = overrun_r;

endmodule
